// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the byte-addressed
// data memory. Port 0 is the load/store unit and port 1 is the debug loader.
// Sub-word stores are done as read-modify-write on whole memory words.
module data_mem_arbiter #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [3:0]  size,
  input  logic [1:0]  uns,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_nx;
  logic        last;
  logic        owner;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, buf_q;

  logic        sel;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic        sel_err;
  logic [31:0] merged;
  logic [31:0] lane;
  logic [1:0]  owner_oh;

  // Round-robin grant, only while idle; on a tie the port that did not win last time goes.
  always_comb begin
    gnt = 2'b00;
    if (rst_n && state == IDLE) begin
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  assign sel      = gnt[1];
  assign sel_we   = sel ? we[1]         : we[0];
  assign sel_size = sel ? size[3:2]     : size[1:0];
  assign sel_addr = sel ? addr[63:32]   : addr[31:0];

  // Illegal size, misalignment, or out-of-range address on the request being granted.
  always_comb begin
    sel_err = 1'b0;
    if (sel_size == 2'b11)                            sel_err = 1'b1;
    if (sel_size == 2'b01 && sel_addr[0])             sel_err = 1'b1;
    if (sel_size == 2'b10 && sel_addr[1:0] != 2'b00)  sel_err = 1'b1;
    if (sel_addr >= MEM_LIMIT)                        sel_err = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state routing: loads read, word stores write directly, sub-word stores read then write.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (|gnt) begin
              if (sel_err)                state_nx = RESP;
              else if (!sel_we)           state_nx = RD;
              else if (sel_size == 2'b10) state_nx = WR;
              else                        state_nx = RD;
            end
      RD:   state_nx = we_q ? WR : RESP;
      WR:   state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch the granted request and capture the memory word during RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= 1'b1;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
    end else begin
      if (|gnt) begin
        last    <= sel;
        owner   <= sel;
        we_q    <= sel_we;
        uns_q   <= sel ? uns[1] : uns[0];
        err_q   <= sel_err;
        size_q  <= sel_size;
        addr_q  <= sel_addr;
        wdata_q <= sel ? wdata[63:32] : wdata[31:0];
      end
      if (state == RD) buf_q <= mem_rdata;
    end
  end

  // Merge store data into the buffered word at the addressed byte lane.
  always_comb begin
    merged = buf_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign lane     = buf_q >> {addr_q[1:0], 3'b000};
  assign owner_oh = owner ? 2'b10 : 2'b01;

  // Memory-side strobes; address and data are held at zero outside RD/WR.
  always_comb begin
    mem_read  = (state == RD);
    mem_write = (state == WR);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == RD || state == WR) mem_addr  = {addr_q[31:2], 2'b00};
    if (state == WR)                mem_wdata = merged;
  end

  // Requester-side response: one-cycle pulse in RESP with the extended load lane.
  always_comb begin
    busy   = (state != IDLE);
    rvalid = 2'b00;
    err    = 2'b00;
    rdata  = '0;
    if (state == RESP) begin
      rvalid = owner_oh;
      if (err_q) err = owner_oh;
      else if (!we_q) begin
        case (size_q)
          2'b00:   rdata = uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
          2'b01:   rdata = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
          default: rdata = buf_q;
        endcase
      end
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and access sequencer for the byte-addressed data memory. It shares the memory between two requesters: port 0 is the core load/store unit and port 1 is the debug/program loader. Requests are granted round-robin. Byte/halfword/word loads and stores are turned into whole-word memory operations, using read-modify-write for sub-word stores. It sits between the requesters and the data memory's `addr`/`write_data`/`mem_write`/`mem_read`/`data_out` pins.

## Interface
- `MEM_BYTES`, default 1024: memory size in bytes; addresses at or above this are errors.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req` in 2: per-port request; bit i belongs to port i.
- `we` in 2: per-port store (1) or load (0).
- `size` in 4: per-port access size, port i uses `size[2i+1:2i]`; 00 byte, 01 half, 10 word, 11 illegal.
- `uns` in 2: per-port zero-extend loads (1) or sign-extend (0).
- `addr` in 64: per-port byte address, port i uses `addr[32i+31:32i]`.
- `wdata` in 64: per-port store data, right-aligned, port i uses `wdata[32i+31:32i]`.
- `gnt` out 2: one-hot acceptance, combinational, asserted only in IDLE.
- `rvalid` out 2: one-hot completion pulse, one cycle long.
- `err` out 2: error flag, valid only with `rvalid`.
- `rdata` out 32: load result, shared by both ports, qualified by `rvalid`.
- `busy` out 1: high when the FSM is not in IDLE.
- `mem_addr` out 32: word-aligned memory address.
- `mem_wdata` out 32: full word to be written.
- `mem_write` out 1: memory write strobe.
- `mem_read` out 1: memory read enable.
- `mem_rdata` in 32: memory read data, combinational from `mem_addr`.

## Operation
- States: IDLE, RD, WR, RESP.
- **IDLE, arbitration**
  - If exactly one `req` bit is high, that port gets `gnt` this cycle.
  - If both are high, grant the port other than `last`.
  - `last` resets to 1, so port 0 wins the first tie.
  - On grant, latch owner, `we`, `size`, `uns`, `addr` and `wdata`, and update `last`. The requester may drop its signals after `gnt`.
- **Error check** (on the latched request)
  - Error cases: `size`=11; half with `addr[0]`=1; word with `addr[1:0]`≠0; `addr` ≥ `MEM_BYTES`.
  - An error goes straight to RESP with `err`=1.
  - No memory access is made, and `rdata`=0.
- **Routing**
  - Load: IDLE→RD→RESP.
  - Word store: IDLE→WR→RESP.
  - Byte or half store: IDLE→RD→WR→RESP.
- **RD**
  - `mem_read`=1 and `mem_addr`={addr[31:2],2'b00}.
  - Capture `mem_rdata` into the word buffer at the clock edge.
- **WR**
  - `mem_write`=1 with the same aligned `mem_addr`.
  - `mem_wdata` is the buffer with the target bytes replaced by `wdata[7:0]` (byte) or `wdata[15:0]` (half), placed at byte lane `addr[1:0]`.
  - For word stores, `mem_wdata` = `wdata`.
- **RESP**
  - Pulse `rvalid[owner]` for one cycle.
  - For loads, `rdata` is the selected lane of the buffer, extended to 32 bits as selected by `uns`.
  - For stores, `rdata`=0.
  - Next state is IDLE.
- **Rules**
  - No grant is given while `busy`; a request made while busy stays pending until IDLE.
  - `mem_write` and `mem_read` are never high together; both are 0 in IDLE and RESP.
  - `mem_addr` and `mem_wdata` are 0 outside RD and WR.
- **Reset**
  - All outputs are 0 on reset: `gnt`, `rvalid`, `err`, `rdata`, `busy`, `mem_*`.
  - FSM goes to IDLE and `last`=1.
  - Reset mid-operation aborts the access immediately: `mem_write` drops without waiting for a clock edge, and no `rvalid` is produced.

## Timing
- Cycle 0 is the cycle in which `gnt` is high.
- Latency from grant to `rvalid`:
  - Load: `rvalid` in cycle 2.
  - Word store: `rvalid` in cycle 2, memory written at the end of cycle 1.
  - Sub-word store: `rvalid` in cycle 3, memory written at the end of cycle 2.
  - Error: `rvalid` in cycle 1.
- Earliest next grant is the cycle after `rvalid`.
- Back-to-back throughput with alternating requesters is one access per 3–4 cycles.

## Test plan
- **Word store then load, port 0**
  - Stimulus: store 0xDEADBEEF @0x10, then load word @0x10.
  - Required: `rdata`=0xDEADBEEF. `rvalid[0]` arrives 2 cycles after each grant. Memory bytes 0x10..0x13 = EF,BE,AD,DE.
- **Byte RMW with sign extension**
  - Stimulus: after the word store above, store byte 0x80 @0x12, then load signed byte @0x12 and load unsigned half @0x12.
  - Required: memory word reads 0xDE80BEEF. Signed byte load gives `rdata`=0xFFFFFF80. Unsigned half load gives `rdata`=0x0000DE80.
- **Simultaneous requests**
  - Stimulus: both `req` held high for 12 cycles after reset, both doing word loads.
  - Required: grants alternate 0,1,0,1. `gnt` is never two-hot. `mem_read`/`mem_write` are never both high.
- **Errors**
  - Stimulus: word load @0x6; half store @0x3; any access @0x400; `size`=11.
  - Required: each gives `rvalid` with `err`=1 one cycle after grant. `mem_write` stays 0 and memory is unchanged.
- **Reset mid-store**
  - Stimulus: assert `rst_n`=0 during the RD state of a byte store @0x20.
  - Required: outputs go to 0 immediately. No write occurs to 0x20..0x23. No `rvalid`. After release, port 0 wins the first tie.
- **Pending request while busy**
  - Stimulus: port 1 raises `req` during port 0's sub-word store.
  - Required: `gnt[1]` is high in the cycle after `rvalid[0]`, not earlier.
